// File: rtl/m_cp0.sv
// Coprocessor-0 exception responder for the M stage: SR/Cause/EPC/PRId, a
// zero-latency exception/interrupt request, mfc0 reads, mtc0 writes and eret.
module m_cp0 #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_2024,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  CP0Add,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (ExcCodeIn != 5'd0) & ~r_exl;
    assign Req       = w_int_req | w_exc_req;

    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exccode, 2'b0};
    assign EPCOut  = r_epc;

    always_comb begin
        CP0Out = 32'd0;
        case (CP0Add)
            5'd12:   CP0Out = w_sr;
            5'd13:   CP0Out = w_cause;
            5'd14:   CP0Out = r_epc;
            5'd15:   CP0Out = PRID_VAL;
            default: CP0Out = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= HWInt;
            if (Req) begin
                // The M instruction is the victim: its mtc0/eret never commit.
                r_exl     <= 1'b1;
                r_exccode <= w_int_req ? 5'd0 : ExcCodeIn;
                r_bd      <= BDIn;
                r_epc     <= BDIn ? VPC - 32'd4 : VPC;
            end else begin
                if (en && CP0Add == 5'd12) begin
                    r_im  <= CP0In[15:10];
                    r_exl <= CP0In[1];
                    r_ie  <= CP0In[0];
                end
                if (en && CP0Add == 5'd14)
                    r_epc <= CP0In;
                // Placed after the SR write so a simultaneous eret still clears EXL.
                if (EXLClr)
                    r_exl <= 1'b0;
            end
        end
    end

endmodule
